// File: rtl/qam16_ber_monitor.sv
// 16-QAM receive monitor: decimates I/Q to one sample per symbol, hard-slices to Gray bits,
// and counts bit errors against a delayed copy of the transmitted bits over a fixed window.
module qam16_ber_monitor #(
    parameter int DATA_W    = 12,
    parameter int SPS       = 4,
    parameter int THRESH    = 512,
    parameter int MAX_DELAY = 32,
    parameter int WIN_LOG2  = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          en,
    input  logic signed [DATA_W-1:0]      rx_I,
    input  logic signed [DATA_W-1:0]      rx_Q,
    input  logic [$clog2(SPS)-1:0]        sample_phase,
    input  logic                          ref_valid,
    input  logic [3:0]                    ref_bits,
    input  logic [$clog2(MAX_DELAY)-1:0]  ref_delay,
    input  logic                          start,
    output logic [3:0]                    sym_bits,
    output logic                          sym_valid,
    output logic                          busy,
    output logic                          done,
    output logic [WIN_LOG2+2:0]           err_count,
    output logic [WIN_LOG2:0]             sym_count
);
    // state | meaning
    // IDLE  | waiting for start, accumulators cleared
    // FLUSH | discarding ref_delay+1 compares while the reference buffer primes
    // COUNT | accumulating symbols and bit errors until the window is full
    // DONE  | window results published; behaves as IDLE

    localparam int PH_W  = $clog2(SPS);
    localparam int PTR_W = $clog2(MAX_DELAY);
    localparam int ERR_W = WIN_LOG2 + 3;
    localparam int SYM_W = WIN_LOG2 + 1;
    localparam logic [SYM_W-1:0]         WIN_LAST = SYM_W'((2 ** WIN_LOG2) - 1);
    localparam logic signed [DATA_W-1:0] T_POS    = DATA_W'(THRESH);
    localparam logic signed [DATA_W-1:0] T_NEG    = DATA_W'(-THRESH);

    typedef enum logic [1:0] {IDLE, FLUSH, COUNT, DONE} state_t;

    state_t             state;
    logic [PH_W-1:0]    phase_cnt;
    logic               decide;
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [3:0]         ref_mem [MAX_DELAY];
    logic [3:0]         ref_sel;
    logic               err_valid;
    logic [2:0]         errs;
    logic [ERR_W-1:0]   err_acc;
    logic [SYM_W-1:0]   sym_acc;
    logic [PTR_W-1:0]   flush_cnt;

    function automatic logic [1:0] slice(input logic signed [DATA_W-1:0] x);
        if (x >= T_POS)        return 2'b10;
        else if (!x[DATA_W-1]) return 2'b11;
        else if (x >= T_NEG)   return 2'b01;
        else                   return 2'b00;
    endfunction

    assign decide = en && (phase_cnt == sample_phase);

    always_ff @(posedge clk) begin
        if (rst) begin
            phase_cnt <= '0;
            sym_valid <= 1'b0;
            sym_bits  <= '0;
        end else begin
            if (en) phase_cnt <= phase_cnt + PH_W'(1);
            sym_valid <= decide;
            if (decide) sym_bits <= {slice(rx_I), slice(rx_Q)};
        end
    end

    // Read pointer trails the write pointer; a write in the same cycle lands after the read.
    assign rd_ptr  = wr_ptr - ref_delay - PTR_W'(1);
    assign ref_sel = ref_mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (ref_valid) ref_mem[wr_ptr] <= ref_bits;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= '0;
            err_valid <= 1'b0;
            errs      <= '0;
        end else begin
            if (ref_valid) wr_ptr <= wr_ptr + PTR_W'(1);
            err_valid <= sym_valid;
            errs      <= 3'($countones(sym_bits ^ ref_sel));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            err_count <= '0;
            sym_count <= '0;
            err_acc   <= '0;
            sym_acc   <= '0;
            flush_cnt <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    err_acc   <= '0;
                    sym_acc   <= '0;
                    flush_cnt <= '0;
                    if (start) begin
                        state <= FLUSH;
                        busy  <= 1'b1;
                    end
                end
                FLUSH: if (err_valid) begin
                    if (flush_cnt == ref_delay) state <= COUNT;
                    flush_cnt <= flush_cnt + PTR_W'(1);
                end
                COUNT: if (err_valid) begin
                    // Last symbol of the window publishes directly so done lands 3 cycles after its en.
                    if (sym_acc == WIN_LAST) begin
                        err_count <= err_acc + ERR_W'(errs);
                        sym_count <= sym_acc + SYM_W'(1);
                        done      <= 1'b1;
                        busy      <= 1'b0;
                        state     <= DONE;
                    end else begin
                        err_acc <= err_acc + ERR_W'(errs);
                        sym_acc <= sym_acc + SYM_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_qam16_ber_monitor.sv
// Directed-plus-random bench for qam16_ber_monitor against an arithmetic reference model.
module tb_qam16_ber_monitor;
    localparam int DATA_W = 12, SPS = 4, T = 512, MD = 32, WIN = 4;

    logic clk = 1'b0;
    logic rst, en, ref_valid, start;
    logic signed [DATA_W-1:0] rx_I, rx_Q;
    logic [1:0] sample_phase;
    logic [3:0] ref_bits;
    logic [4:0] ref_delay;
    logic [3:0] sym_bits;
    logic sym_valid, busy, done;
    logic [WIN+2:0] err_count;
    logic [WIN:0] sym_count;

    qam16_ber_monitor #(.DATA_W(DATA_W), .SPS(SPS), .THRESH(T), .MAX_DELAY(MD), .WIN_LOG2(WIN)) dut (
        .clk(clk), .rst(rst), .en(en), .rx_I(rx_I), .rx_Q(rx_Q), .sample_phase(sample_phase),
        .ref_valid(ref_valid), .ref_bits(ref_bits), .ref_delay(ref_delay), .start(start),
        .sym_bits(sym_bits), .sym_valid(sym_valid), .busy(busy), .done(done),
        .err_count(err_count), .sym_count(sym_count));

    always #5 clk = ~clk;

    int n_tests = 0, n_fail = 0;
    int phase_m = 0, step_n = 0;
    logic [3:0] last_bits = 4'd0;
    int done_cnt, done_step, valid_seen, exp_dec;
    logic busy_last, busy_at_done, busy_before_done;
    int prev_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0d want %0d", tag, got, exp);
        end
    endtask

    // Region index from plain arithmetic, then Gray label per region.
    function automatic logic [1:0] slice_m(input int x);
        logic [1:0] gray [4] = '{2'b00, 2'b01, 2'b11, 2'b10};
        int idx;
        idx = x + 2 * T;
        if (idx < 0) idx = 0;
        else idx = idx / T;
        if (idx > 3) idx = 3;
        return gray[idx];
    endfunction

    function automatic int lvl(input logic [1:0] b);
        case (b)
            2'b00:   return -3 * T / 2;
            2'b01:   return -T / 2;
            2'b11:   return T / 2;
            default: return 3 * T / 2;
        endcase
    endfunction

    function automatic int rnd_s();
        return int'($urandom_range(4095, 0)) - 2048;
    endfunction

    function automatic int noise();
        return int'($urandom_range(400, 0)) - 200;
    endfunction

    task automatic step(input logic e, input int i, input int q, input logic rv,
                        input logic [3:0] rb, input logic st);
        logic exp_v;
        logic [3:0] exp_b;
        step_n++;
        en = e; rx_I = DATA_W'(i); rx_Q = DATA_W'(q);
        ref_valid = rv; ref_bits = rb; start = st;
        exp_v = e && (phase_m == int'(sample_phase));
        exp_b = {slice_m(i), slice_m(q)};
        if (e) phase_m = (phase_m + 1) % SPS;
        if (exp_v) exp_dec++;
        @(posedge clk); #1;
        if (exp_v) last_bits = exp_b;
        chk("sym_valid", 32'(sym_valid), 32'(exp_v));
        chk("sym_bits", 32'(sym_bits), 32'(last_bits));
        if (sym_valid) valid_seen++;
        if (done) begin
            done_cnt++;
            done_step = step_n;
            busy_at_done = busy;
            busy_before_done = busy_last;
        end
        busy_last = busy;
        en = 1'b0; ref_valid = 1'b0; start = 1'b0;
    endtask

    // Reset applied with en/start active to show reset dominates.
    task automatic do_reset();
        rst = 1'b1; en = 1'b1; start = 1'b1; rx_I = 12'sd768; rx_Q = 12'sd768;
        @(posedge clk); #1;
        chk("rst sym_valid", 32'(sym_valid), 0);
        chk("rst sym_bits", 32'(sym_bits), 0);
        chk("rst busy", 32'(busy), 0);
        chk("rst done", 32'(done), 0);
        chk("rst err_count", 32'(err_count), 0);
        chk("rst sym_count", 32'(sym_count), 0);
        rst = 1'b0; en = 1'b0; start = 1'b0;
        phase_m = 0; last_bits = 4'd0; busy_last = 1'b0;
    endtask

    task automatic run_window(input int d, input int corrupt, input int noise_pct,
                              input int poke_k, input int rst_k);
        logic [3:0] refs [$];
        logic [3:0] rx;
        int n, total, exp_err, exp_sym, last0;
        n = 1 << WIN;
        total = d + 1 + n;
        ref_delay = 5'(d);
        sample_phase = 2'd0;
        while (phase_m != 0) step(1'b1, rnd_s(), rnd_s(), 1'b0, 4'd0, 1'b0);
        step(1'b0, 0, 0, 1'b0, 4'd0, 1'b1);
        done_cnt = 0; exp_err = 0; exp_sym = 0; last0 = 0;
        refs = {};
        for (int j = 0; j < total; j++) refs.push_back(4'($urandom));
        if (corrupt >= 0) refs[corrupt - 1 - d] = 4'b1001;
        for (int k = 0; k < total; k++) begin
            if (k == rst_k) begin
                chk("err_count held", 32'(err_count), prev_err);
                chk("busy mid window", 32'(busy), 1);
                do_reset();
                return;
            end
            if (k >= d + 1) rx = refs[k - 1 - d];
            else rx = 4'($urandom);
            if (k == corrupt) rx = 4'b1111;
            else if (int'($urandom_range(99, 0)) < noise_pct) rx = 4'($urandom);
            if (k >= d + 1) begin
                exp_sym++;
                exp_err += $countones(rx ^ refs[k - 1 - d]);
            end
            step(1'b1, lvl(rx[3:2]) + noise(), lvl(rx[1:0]) + noise(), 1'b0, 4'd0, k == poke_k);
            last0 = step_n;
            step(1'b1, rnd_s(), rnd_s(), 1'b1, refs[k], 1'b0);
            step(1'b1, rnd_s(), rnd_s(), 1'b0, 4'd0, 1'b0);
            step(1'b1, rnd_s(), rnd_s(), 1'b0, 4'd0, 1'b0);
        end
        repeat (4) step(1'b0, 0, 0, 1'b0, 4'd0, 1'b0);
        chk("done pulses", done_cnt, 1);
        chk("done timing", done_step, last0 + 2);
        chk("busy at done", 32'(busy_at_done), 0);
        chk("busy before done", 32'(busy_before_done), 1);
        chk("err_count", 32'(err_count), exp_err);
        chk("sym_count", 32'(sym_count), exp_sym);
        chk("busy after", 32'(busy), 0);
        prev_err = exp_err;
    endtask

    initial begin
        int edge_vals [6] = '{511, 512, 0, -1, -512, -513};
        rst = 1'b1; en = 1'b0; start = 1'b0; ref_valid = 1'b0; ref_bits = 4'd0;
        rx_I = '0; rx_Q = '0; sample_phase = 2'd0; ref_delay = 5'd0;
        valid_seen = 0; exp_dec = 0; done_cnt = 0; done_step = 0;
        busy_last = 1'b0; busy_at_done = 1'b0; busy_before_done = 1'b0;
        do_reset();

        // Decoding at phase 0, other phases silent
        step(1'b1, 768, -256, 1'b0, 4'd0, 1'b0);
        chk("decode 1001", 32'(sym_bits), 32'(4'b1001));
        repeat (3) step(1'b1, rnd_s(), rnd_s(), 1'b0, 4'd0, 1'b0);

        // Threshold edges on I with Q=0
        foreach (edge_vals[i]) begin
            step(1'b1, edge_vals[i], 0, 1'b0, 4'd0, 1'b0);
            repeat (3) step(1'b1, rnd_s(), rnd_s(), 1'b0, 4'd0, 1'b0);
        end

        // Random full-range slicing
        repeat (160) step(1'b1, rnd_s(), rnd_s(), 1'b0, 4'd0, 1'b0);

        // Phase 2 with every-other-cycle en, then random gaps
        do_reset();
        sample_phase = 2'd2;
        valid_seen = 0; exp_dec = 0;
        repeat (16) begin
            step(1'b1, rnd_s(), rnd_s(), 1'b0, 4'd0, 1'b0);
            step(1'b0, rnd_s(), rnd_s(), 1'b0, 4'd0, 1'b0);
        end
        step(1'b0, 0, 0, 1'b0, 4'd0, 1'b0);
        chk("decisions per 16 en", valid_seen, 4);
        valid_seen = 0; exp_dec = 0;
        repeat (60) step(1'($urandom), rnd_s(), rnd_s(), 1'b0, 4'd0, 1'b0);
        step(1'b0, 0, 0, 1'b0, 4'd0, 1'b0);
        chk("decisions with gaps", valid_seen, exp_dec);

        run_window(3, 10, 0, -1, -1);
        run_window(3, -1, 10, 6, -1);
        run_window(2, -1, 20, -1, 8);
        run_window(0, -1, 0, -1, -1);
        run_window(int'($urandom_range(31, 0)), -1, 15, -1, -1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1, "watchdog");
    end
endmodule
